// File: rtl/fpu_pkg.sv
// Shared FPU issue-stage types: operand classes, field positions,
// the tagged-result record and the operand classifier.
package fpu_pkg;

    localparam int          SIGN_BIT  = 31;
    localparam int          EXP_MSB   = 30;
    localparam int          EXP_LSB   = 23;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    // Tag width carried by the result record; issue stages use tags no wider.
    localparam int          FPU_TAG_W = 5;

    typedef enum logic [1:0] {
        FC_NORM = 2'd0,
        FC_ZERO = 2'd1,
        FC_SPEC = 2'd2
    } fclass_t;

    typedef struct packed {
        logic [31:0]          y;
        logic [FPU_TAG_W-1:0] tag;
    } fres_t;

    // Zero and denormals share FC_ZERO; Inf and NaN share FC_SPEC.
    function automatic fclass_t classify(input logic [31:0] x);
        logic [7:0] e;
        fclass_t    c;
        e = x[EXP_MSB:EXP_LSB];
        if (e == 8'h00) begin
            c = FC_ZERO;
        end else if (e == EXP_MAX) begin
            c = FC_SPEC;
        end else begin
            c = FC_NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/fhalf_issue_if.sv
// Operand and result handshakes of the fhalf issue sequencer.
interface fhalf_issue_if #(
    parameter int TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_x;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_x, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_tag
    );

    modport slave (
        input  in_valid, in_x, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_tag
    );
endinterface

// File: rtl/fpu_res_fifo.sv
// In-order result FIFO with an occupancy count; head reads as zero when empty.
module fpu_res_fifo #(
    parameter  int W     = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     head,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] n;
        if (p == PTR_W'(DEPTH - 1)) begin
            n = '0;
        end else begin
            n = p + PTR_W'(1);
        end
        return n;
    endfunction

    // A pop frees a slot in the same cycle, so push into a full FIFO is legal then.
    always_comb begin
        w_do_pop  = pop && (r_cnt != '0);
        w_do_push = push && ((r_cnt != CNT_FULL) || w_do_pop);
    end

    // Read/write pointers and occupancy count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) begin
                r_wr <= ptr_inc(r_wr);
            end
            if (w_do_pop) begin
                r_rd <= ptr_inc(r_rd);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr] <= din;
        end
    end

    assign head  = (r_cnt != '0) ? r_mem[r_rd] : '0;
    assign count = r_cnt;

endmodule

// File: rtl/fhalf_issue.sv
// Issue/retire sequencer around the external fhalf (x*0.5) unit: classifies
// operands, bypasses zero/denormal and Inf/NaN, and retires results in order
// through a credit-limited result FIFO.
module fhalf_issue
    import fpu_pkg::*;
#(
    parameter int TAG_W    = FPU_TAG_W,
    parameter int UNIT_LAT = 1,
    parameter int DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rstn,
    fhalf_issue_if.slave  bus,
    output logic [31:0]   unit_x,
    input  logic [31:0]   unit_y,
    output logic          busy
);

    localparam int               OCC_W   = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);
    localparam int               LAST    = UNIT_LAT - 1;

    // S0: operand currently presented to fhalf.
    logic             r_s0_valid;
    logic [31:0]      r_s0_x;
    logic [TAG_W-1:0] r_s0_tag;
    fclass_t          r_s0_cls;

    // Pipe stages running alongside fhalf's internal latency.
    logic             r_pv   [UNIT_LAT];
    logic [TAG_W-1:0] r_ptag [UNIT_LAT];
    fclass_t          r_pcls [UNIT_LAT];
    logic [31:0]      r_px   [UNIT_LAT];

    logic [OCC_W-1:0] r_occ;
    logic             w_in_ready;
    logic             w_acc;
    logic             w_pop;
    logic             w_out_valid;
    fres_t            w_res;
    fres_t            w_head;
    logic [OCC_W-1:0] w_fifo_cnt;

    // Credit depends only on registered occupancy, never on the handshakes.
    assign w_in_ready  = (r_occ < OCC_MAX);
    assign w_acc       = bus.in_valid && w_in_ready;
    assign w_out_valid = (w_fifo_cnt != '0);
    assign w_pop       = w_out_valid && bus.out_ready;

    // Ops in flight across S0, pipe and FIFO.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_occ <= '0;
        end else begin
            case ({w_acc, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // S0 capture; the operand is held between accepts so unit_x stays quiet.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s0_valid <= 1'b0;
            r_s0_x     <= 32'd0;
            r_s0_tag   <= '0;
            r_s0_cls   <= FC_NORM;
        end else begin
            r_s0_valid <= w_acc;
            if (w_acc) begin
                r_s0_x   <= bus.in_x;
                r_s0_tag <= bus.in_tag;
                r_s0_cls <= classify(bus.in_x);
            end
        end
    end

    // Metadata shift matching fhalf's latency; it never stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < UNIT_LAT; i++) begin
                r_pv[i]   <= 1'b0;
                r_ptag[i] <= '0;
                r_pcls[i] <= FC_NORM;
                r_px[i]   <= 32'd0;
            end
        end else begin
            r_pv[0]   <= r_s0_valid;
            r_ptag[0] <= r_s0_tag;
            r_pcls[0] <= r_s0_cls;
            r_px[0]   <= r_s0_x;
            for (int i = 1; i < UNIT_LAT; i++) begin
                r_pv[i]   <= r_pv[i-1];
                r_ptag[i] <= r_ptag[i-1];
                r_pcls[i] <= r_pcls[i-1];
                r_px[i]   <= r_px[i-1];
            end
        end
    end

    // Result select: fhalf output for normals, exact bypass otherwise.
    always_comb begin
        w_res     = '0;
        w_res.tag = FPU_TAG_W'(r_ptag[LAST]);
        case (r_pcls[LAST])
            FC_NORM: w_res.y = unit_y;
            FC_ZERO: w_res.y = {r_px[LAST][SIGN_BIT], 31'd0};
            FC_SPEC: w_res.y = r_px[LAST];
            default: w_res.y = r_px[LAST];
        endcase
    end

    fpu_res_fifo #(
        .W     ($bits(fres_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (r_pv[LAST]),
        .din   (w_res),
        .pop   (w_pop),
        .head  (w_head),
        .count (w_fifo_cnt)
    );

    assign unit_x        = r_s0_x;
    assign busy          = (r_occ != '0);
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_y     = w_head.y;
    assign bus.out_tag   = TAG_W'(w_head.tag);

endmodule

// File: tb/tb_fhalf_issue.sv
// Bench for fhalf_issue: directed test-plan steps plus randomized traffic,
// checked against a queue-based reference of in-flight ops.
module tb_fhalf_issue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] unit_x;
    logic [31:0] unit_y = 32'd0;
    logic        busy;
    logic        force_dead = 1'b0;

    fhalf_issue_if #(.TAG_W(5)) bus ();

    fhalf_issue #(.TAG_W(5), .UNIT_LAT(1), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus    (bus),
        .unit_x (unit_x),
        .unit_y (unit_y),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // x*0.5 with round-to-nearest-even when the result goes denormal.
    function automatic logic [31:0] unit_half(input logic [31:0] x);
        logic [7:0]  e;
        logic [23:0] m;
        logic [31:0] r;
        e = x[30:23];
        if (e > 8'd1 && e != 8'hFF) begin
            r = {x[31], e - 8'd1, x[22:0]};
        end else if (e == 8'd1) begin
            m = {1'b1, x[22:0]};
            r = {x[31], 8'd0, m[23:1]};
            if (m[0] && m[1]) r = r + 32'd1;
        end else begin
            r = x;
        end
        return r;
    endfunction

    // fhalf stand-in: one register stage.
    always @(posedge clk) unit_y <= force_dead ? 32'hDEADBEEF : unit_half(unit_x);

    // What the sequencer should return for an operand.
    function automatic logic [31:0] ref_result(input logic [31:0] x);
        if (x[30:23] == 8'h00) return {x[31], 31'd0};
        if (x[30:23] == 8'hFF) return x;
        return unit_half(x);
    endfunction

    function automatic logic [31:0] rand_x();
        logic [7:0] e;
        case ($urandom_range(0, 4))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'h01;
            3:       e = 8'hFE;
            default: e = 8'($urandom_range(2, 253));
        endcase
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    typedef struct {
        logic [31:0] y;
        logic [4:0]  tag;
        int          avail;
    } exp_t;

    exp_t        q[$];
    logic [4:0]  pop_tags[$];
    int          pop_cycles[$];
    int          cycle = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] drv_exp = 32'd0;
    bit          last_acc;

    logic [31:0] byp_x [4] = '{32'h00400000, 32'h80000001, 32'h7F800000, 32'hFFC00001};
    logic [31:0] byp_e [4] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFFC00001};

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic bit head_ready();
        if (q.size() == 0) return 1'b0;
        return q[0].avail <= cycle;
    endfunction

    task automatic check_outputs();
        bit v;
        v = head_ready();
        chk("in_ready", 32'(bus.in_ready), 32'(q.size() < DEPTH));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("out_valid", 32'(bus.out_valid), 32'(v));
        chk("out_y", bus.out_y, v ? q[0].y : 32'd0);
        chk("out_tag", 32'(bus.out_tag), v ? 32'(q[0].tag) : 32'd0);
    endtask

    // One clock: predict handshakes, advance, update model, check outputs.
    task automatic cyc();
        bit          acc;
        bit          pop;
        exp_t        e;
        acc     = bus.in_valid && (q.size() < DEPTH);
        pop     = bus.out_ready && head_ready();
        e.y     = drv_exp;
        e.tag   = bus.in_tag;
        @(posedge clk);
        cycle++;
        if (pop) begin
            pop_tags.push_back(q[0].tag);
            pop_cycles.push_back(cycle);
            void'(q.pop_front());
        end
        if (acc) begin
            e.avail = cycle + 2;
            q.push_back(e);
        end
        last_acc = acc;
        #1;
        check_outputs();
    endtask

    task automatic set_op(input logic [31:0] x, input logic [4:0] tag, input logic [31:0] e);
        bus.in_x     = x;
        bus.in_tag   = tag;
        drv_exp      = e;
        bus.in_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    // Issue one op and check it surfaces exactly on the third edge.
    task automatic single_op(input string name, input logic [31:0] x, input logic [4:0] tag,
                             input logic [31:0] e);
        int k;
        set_op(x, tag, e);
        cyc();
        chk({name, "_acc"}, 32'(last_acc), 32'd1);
        k = cycle;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.out_valid) break;
            cyc();
        end
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, "_lat"}, 32'(cycle), 32'(k + 2));
        chk({name, "_y"}, bus.out_y, e);
        chk({name, "_tag"}, 32'(bus.out_tag), 32'(tag));
        cyc();
        chk({name, "_busy_after_pop"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int acc_n;
        logic [31:0] x;

        rstn          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_x      = 32'd0;
        bus.in_tag    = 5'd0;
        bus.out_ready = 1'b1;
        #2;
        check_outputs();
        chk("reset_unit_x", unit_x, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Basic
        single_op("basic", 32'h40000000, 5'd3, 32'h3F800000);

        // Bypass classes: unit output must never be used.
        force_dead = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) begin
            set_op(byp_x[i], 5'(i), byp_e[i]);
            cyc();
        end
        idle(6);
        force_dead = 1'b0;
        idle(1);

        // Edge exponents
        single_op("edge_max", 32'h7F7FFFFF, 5'd7, 32'h7EFFFFFF);
        single_op("edge_min", 32'h00800000, 5'd8, 32'h00400000);

        // Streaming
        pop_tags.delete();
        pop_cycles.delete();
        for (int i = 0; i < 16; i++) begin
            x = rand_x();
            set_op(x, 5'(i), ref_result(x));
            chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
            cyc();
        end
        idle(6);
        chk("stream_count", 32'(pop_tags.size()), 32'd16);
        for (int i = 0; i < pop_tags.size(); i++) begin
            chk("stream_order", 32'(pop_tags[i]), 32'(i));
            chk("stream_consec", 32'(pop_cycles[i]), 32'(pop_cycles[0] + i));
        end

        // Backpressure
        pop_tags.delete();
        bus.out_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 8; i++) begin
            x = rand_x();
            set_op(x, 5'(acc_n), ref_result(x));
            cyc();
            if (last_acc) acc_n++;
        end
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_accepts", 32'(acc_n), 32'd4);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 30 && (acc_n < 6 || q.size() != 0); i++) begin
            if (acc_n < 6) begin
                x = rand_x();
                set_op(x, 5'(acc_n), ref_result(x));
            end else begin
                bus.in_valid = 1'b0;
            end
            cyc();
            if (last_acc) acc_n++;
        end
        bus.in_valid = 1'b0;
        chk("bp_total", 32'(acc_n), 32'd6);
        chk("bp_pops", 32'(pop_tags.size()), 32'd6);
        for (int i = 0; i < pop_tags.size(); i++) begin
            chk("bp_order", 32'(pop_tags[i]), 32'(i));
        end

        // Reset mid-flight
        for (int i = 0; i < 3; i++) begin
            set_op(32'h40400000 + 32'(i), 5'(20 + i), unit_half(32'h40400000 + 32'(i)));
            cyc();
        end
        bus.in_valid = 1'b0;
        rstn = 1'b0;
        #1;
        q.delete();
        check_outputs();
        chk("mid_reset_unit_x", unit_x, 32'd0);
        #2;
        rstn = 1'b1;
        idle(8);
        single_op("post_reset", 32'hC1000000, 5'd9, 32'hC0800000);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            x = rand_x();
            set_op(x, 5'($urandom_range(0, 31)), ref_result(x));
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        bus.out_ready = 1'b1;
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fhalf_issue.md
Name: fhalf_issue

Overview:
- Issue/retire sequencer wrapped around the `fhalf` (x*0.5) datapath in the FPU.
- Accepts operands over a valid/ready handshake and drives `fhalf` through the `unit_x` / `unit_y` ports.
- Classifies each operand so that operand classes outside `fhalf`'s supported range get an exact bypass result.
- Returns results in order, with a tag, through a credit-limited result FIFO.

Parameters:
- TAG_W, 5, width of the destination tag (register index) carried with each op.
- UNIT_LAT, 1, clock edges from `unit_x` stable to `unit_y` valid (`fhalf` registers its output once).
- DEPTH, 4, maximum ops in flight (S0 + pipe + FIFO); must be >= UNIT_LAT+3 for one-per-cycle throughput.

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operand offered
- in_ready  out  1  operand accepted when in_valid && in_ready
- in_x  in  32  IEEE-754 single operand
- in_tag  in  TAG_W  destination tag
- unit_x  out  32  operand to `fhalf`
- unit_y  in  32  `fhalf` result
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head when out_valid && out_ready
- out_y  out  32  result
- out_tag  out  TAG_W  tag of result
- busy  out  1  occupancy != 0

Behaviour:
- Reset: S0 valid, pipe valids, FIFO pointers and occupancy cleared.
  - out_valid=0, busy=0, in_ready=1, unit_x=0.
  - out_y/out_tag=0 while empty.
  - Reset mid-operation drops every in-flight op; no result for those ops ever appears.
- in_ready = (occ < DEPTH), with no combinational path from out_ready or in_valid.
- occ: +1 on accept, -1 on pop, unchanged when both happen in the same cycle; never exceeds DEPTH.
- Accept edge k: S0 <= {valid, in_x, in_tag, class}. unit_x = S0 operand, held while S0 is not valid.
- Class from in_x[30:23]:
  - ZERO: exp==0, covering zero and denormal.
  - SPEC: exp==255, covering Inf and NaN.
  - NORM: otherwise.
- {valid, tag, class, sign, raw x} shift through UNIT_LAT pipe stages alongside `fhalf`.
- At edge k+UNIT_LAT+1 the FIFO is written with:
  - NORM: unit_y, bit-exact.
  - ZERO: {sign, 31'b0}.
  - SPEC: raw x, unchanged.
- out_valid is high from after edge k+UNIT_LAT+1, so latency is UNIT_LAT+2 edges (3 at default).
- Pipe never stalls: the credit guarantees a free FIFO slot at write.
- FIFO: DEPTH entries, in-order.
  - Pointers wrap modulo DEPTH; a count or extra-bit scheme distinguishes full from empty.
  - Simultaneous write and pop on a 1-entry FIFO: the head updates to the new entry with no bubble.
  - Write into an empty FIFO appears at out_y the next cycle, not combinationally.
- out_y/out_tag stay stable while out_valid && !out_ready.
- Tags are opaque; the same tag may be issued repeatedly.

Decomposition:
- Package `fpu_pkg`:
  - typedef fclass_t {FC_NORM, FC_ZERO, FC_SPEC}.
  - Constants EXP_MSB=30, EXP_LSB=23, SIGN_BIT=31, EXP_MAX=8'hFF.
  - Function classify(x).
  - Tagged-result struct {y, tag}.
- Sub-module `fpu_res_fifo` (params W, DEPTH):
  - Push, pop, head, count.
  - Reusable by other FPU issue stages.
- `fhalf` is instantiated by the bench or the parent, not inside this block.

Test Plan:
- Basic: in_x=0x40000000 tag=3, out_ready=1 -> out_y=0x3F800000, out_tag=3, exactly 3 edges after accept; busy drops the cycle after pop.
- Bypass: 0x00400000 -> 0x00000000; 0x80000001 -> 0x80000000; 0x7F800000 -> 0x7F800000; 0xFFC00001 -> 0xFFC00001. In every case unit_y is ignored: bench forces unit_y=0xDEADBEEF.
- Edge exponent: 0x7F7FFFFF -> 0x7EFFFFFF; 0x00800000 -> `fhalf` result passed through bit-exact.
- Streaming: 16 back-to-back ops, tags 0..15, out_ready=1 -> in_ready never drops; 16 results arrive in consecutive cycles in tag order.
- Backpressure: out_ready=0, offer 6 ops -> in_ready=0 after 4 accepts. Then set out_ready=1 -> tags 0..3 drain in order, remaining 2 accepted, 6 total and none duplicated.
- Reset mid-flight: 3 ops accepted, rstn pulsed low between edges -> out_valid=0, busy=0, in_ready=1 immediately. No stale result afterwards; a new op returns in 3 edges.
